// File: rtl/uart_baud_tick_generator.sv
// uart_baud_tick_generator
//
// Programmable baud-rate tick source shared by the UART transmit and receive
// cores. The system clock is divided by (active divisor + 1) to give an
// oversample tick; every OVERSAMPLE oversample ticks form one bit period.
// Three phase-locked pulses come out of the same counter chain:
//   os_tick  - every oversample period (receiver sampling)
//   mid_tick - on the oversample tick that closes the first half of a bit
//              (receiver centre sample)
//   bit_tick - on the oversample tick that closes the bit (transmit shift)
// A newly loaded divisor waits in a pending register and only takes effect at
// a bit boundary, so no shortened or stretched bit is ever produced.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   enable        1 = counters run, 0 = counters hold and no ticks
//   divisor_in    new divisor (oversample period = divisor + 1 clocks)
//   divisor_load  one-cycle strobe capturing divisor_in as pending divisor
//   restart       one-cycle strobe zeroing both counters and applying any
//                 pending divisor immediately
//   os_tick       one-cycle oversample pulse
//   mid_tick      one-cycle mid-bit pulse, coincident with an os_tick
//   bit_tick      one-cycle end-of-bit pulse, coincident with an os_tick
//   divisor_out   divisor currently in use
//   load_pending  a loaded divisor is waiting for the next bit boundary

module uart_baud_tick_generator #(
   parameter int                   DIV_WIDTH   = 16,
   parameter int                   OVERSAMPLE  = 16,
   parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(650)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [DIV_WIDTH-1:0] divisor_in,
   input  logic                 divisor_load,
   input  logic                 restart,
   output logic                 os_tick,
   output logic                 mid_tick,
   output logic                 bit_tick,
   output logic [DIV_WIDTH-1:0] divisor_out,
   output logic                 load_pending
);

   localparam int                  OS_WIDTH = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [OS_WIDTH-1:0] OS_LAST  = OS_WIDTH'(OVERSAMPLE - 1);
   localparam logic [OS_WIDTH-1:0] OS_MID   = OS_WIDTH'(OVERSAMPLE / 2 - 1);

   logic [DIV_WIDTH-1:0] pre_count_q,   pre_count_d;
   logic [OS_WIDTH-1:0]  os_count_q,    os_count_d;
   logic [DIV_WIDTH-1:0] active_div_q,  active_div_d;
   logic [DIV_WIDTH-1:0] pending_div_q, pending_div_d;
   logic                 load_pending_q, load_pending_d;
   logic                 os_tick_q,     os_tick_d;
   logic                 mid_tick_q,    mid_tick_d;
   logic                 bit_tick_q,    bit_tick_d;

   logic pre_wrap;
   logic os_last;

   // The prescaler wraps when it reaches the active divisor. Because the
   // active divisor only changes while the prescaler is zero, equality is
   // always reached and no greater-than guard is needed.
   assign pre_wrap = (pre_count_q == active_div_q);
   assign os_last  = (os_count_q == OS_LAST);

   // Next-state logic. Restart overrides enable and normal counting. When a
   // restart coincides with a divisor load the fresh value goes straight into
   // service; otherwise a waiting pending divisor is promoted. In normal
   // running a pending divisor is promoted only on the wrap that closes a
   // bit, which is also when the prescaler restarts from zero. A load that
   // lands on that same wrap is kept pending for the following boundary.
   always_comb begin
      pre_count_d    = pre_count_q;
      os_count_d     = os_count_q;
      active_div_d   = active_div_q;
      pending_div_d  = pending_div_q;
      load_pending_d = load_pending_q;
      os_tick_d      = 1'b0;
      mid_tick_d     = 1'b0;
      bit_tick_d     = 1'b0;

      if (restart) begin
         pre_count_d = '0;
         os_count_d  = '0;
         if (divisor_load) begin
            active_div_d   = divisor_in;
            pending_div_d  = divisor_in;
            load_pending_d = 1'b0;
         end else if (load_pending_q) begin
            active_div_d   = pending_div_q;
            load_pending_d = 1'b0;
         end
      end else begin
         if (enable) begin
            if (pre_wrap) begin
               pre_count_d = '0;
               os_tick_d   = 1'b1;
               mid_tick_d  = (os_count_q == OS_MID);
               bit_tick_d  = os_last;
               if (os_last) begin
                  os_count_d = '0;
                  if (load_pending_q) begin
                     active_div_d   = pending_div_q;
                     load_pending_d = 1'b0;
                  end
               end else begin
                  os_count_d = os_count_q + OS_WIDTH'(1);
               end
            end else begin
               pre_count_d = pre_count_q + DIV_WIDTH'(1);
            end
         end
         if (divisor_load) begin
            pending_div_d  = divisor_in;
            load_pending_d = 1'b1;
         end
      end
   end

   // State and output registers. Reset drops everything back to the default
   // divisor at once, cancelling any tick in flight and any pending load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_count_q    <= '0;
         os_count_q     <= '0;
         active_div_q   <= DEFAULT_DIV;
         pending_div_q  <= DEFAULT_DIV;
         load_pending_q <= 1'b0;
         os_tick_q      <= 1'b0;
         mid_tick_q     <= 1'b0;
         bit_tick_q     <= 1'b0;
      end else begin
         pre_count_q    <= pre_count_d;
         os_count_q     <= os_count_d;
         active_div_q   <= active_div_d;
         pending_div_q  <= pending_div_d;
         load_pending_q <= load_pending_d;
         os_tick_q      <= os_tick_d;
         mid_tick_q     <= mid_tick_d;
         bit_tick_q     <= bit_tick_d;
      end
   end

   assign os_tick      = os_tick_q;
   assign mid_tick     = mid_tick_q;
   assign bit_tick     = bit_tick_q;
   assign divisor_out  = active_div_q;
   assign load_pending = load_pending_q;

endmodule

// File: tb/tb_uart_baud_tick_generator.sv
// tb_uart_baud_tick_generator
//
// Bench for uart_baud_tick_generator built with DEFAULT_DIV=3, OVERSAMPLE=4.
// A reference model tracks only the number of enabled cycles elapsed in the
// current bit and derives every tick from that with plain arithmetic. Its
// expectations are compared against the DUT on every falling edge, and
// directed scenarios add hand-computed literal expectations.

module tb_uart_baud_tick_generator;

   localparam int OS  = 4;
   localparam int DEF = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [15:0] divisorIn;
   logic        divisorLoad;
   logic        restart;
   logic        osTick;
   logic        midTick;
   logic        bitTick;
   logic [15:0] divisorOut;
   logic        loadPending;

   int checks = 0;
   int fails  = 0;
   bit checking = 1'b0;

   int  osSeen, midSeen, bitSeen;
   bit  sawFive;

   uart_baud_tick_generator #(
      .DIV_WIDTH   (16),
      .OVERSAMPLE  (OS),
      .DEFAULT_DIV (16'd3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .divisor_in   (divisorIn),
      .divisor_load (divisorLoad),
      .restart      (restart),
      .os_tick      (osTick),
      .mid_tick     (midTick),
      .bit_tick     (bitTick),
      .divisor_out  (divisorOut),
      .load_pending (loadPending)
   );

   always #5 clk = ~clk;

   // Reference state: cycles elapsed inside the current bit, divisor in use,
   // pending divisor and its flag, and the ticks expected after this edge.
   typedef struct packed {
      int phase;
      int div;
      int pend;
      bit lp;
      bit os;
      bit mid;
      bit bitT;
   } model_t;

   model_t m;

   // One clock of the reference behaviour. The ticks fall out of the elapsed
   // count p within a bit of length (div+1)*OS: an oversample tick whenever p
   // is a multiple of div+1, mid-bit at half the bit, bit tick at its end.
   function automatic model_t nextModel(model_t s, bit en, bit rs, bit ld, int din);
      model_t n;
      int per;
      int p;
      n      = s;
      n.os   = 1'b0;
      n.mid  = 1'b0;
      n.bitT = 1'b0;
      per    = s.div + 1;
      p      = s.phase + 1;
      if (rs) begin
         n.phase = 0;
         if (ld) begin
            n.div  = din;
            n.pend = din;
            n.lp   = 1'b0;
         end else if (s.lp) begin
            n.div = s.pend;
            n.lp  = 1'b0;
         end
      end else begin
         if (en) begin
            n.os    = (p % per == 0);
            n.mid   = (p == per * OS / 2);
            n.bitT  = (p == per * OS);
            n.phase = n.bitT ? 0 : p;
            if (n.bitT && s.lp) begin
               n.div = s.pend;
               n.lp  = 1'b0;
            end
         end
         if (ld) begin
            n.pend = din;
            n.lp   = 1'b1;
         end
      end
      return n;
   endfunction

   // Reference model advances on the same edges as the DUT, including the
   // asynchronous reset.
   always @(posedge clk or posedge reset) begin
      if (reset)
         m <= '{phase: 0, div: DEF, pend: DEF, lp: 1'b0, os: 1'b0, mid: 1'b0, bitT: 1'b0};
      else
         m <= nextModel(m, enable, restart, divisorLoad, int'(divisorIn));
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Continuous comparison against the reference model, away from the
   // rising edge.
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("model.os_tick",      32'(osTick),      32'(m.os));
         checkOutput("model.mid_tick",     32'(midTick),     32'(m.mid));
         checkOutput("model.bit_tick",     32'(bitTick),     32'(m.bitT));
         checkOutput("model.divisor_out",  32'(divisorOut),  32'(m.div));
         checkOutput("model.load_pending", 32'(loadPending), 32'(m.lp));
      end
   end

   // Advance n clocks, settling just after each rising edge and tallying the
   // ticks seen.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (osTick)  osSeen++;
         if (midTick) midSeen++;
         if (bitTick) bitSeen++;
         if (divisorOut == 16'd5) sawFive = 1'b1;
      end
   endtask

   task automatic clearCounts();
      osSeen  = 0;
      midSeen = 0;
      bitSeen = 0;
   endtask

   task automatic checkCounts(input string name, input int expOs, input int expMid, input int expBit);
      checkOutput({name, ".os_count"},  32'(osSeen),  32'(expOs));
      checkOutput({name, ".mid_count"}, 32'(midSeen), 32'(expMid));
      checkOutput({name, ".bit_count"}, 32'(bitSeen), 32'(expBit));
   endtask

   initial begin
      bit found;
      reset       = 1'b0;
      enable      = 1'b0;
      divisorIn   = '0;
      divisorLoad = 1'b0;
      restart     = 1'b0;
      sawFive     = 1'b0;
      clearCounts();

      // Reset state
      #1 reset = 1'b1;
      #1 checking = 1'b1;
      checkOutput("reset.os_tick",      32'(osTick),      32'd0);
      checkOutput("reset.bit_tick",     32'(bitTick),     32'd0);
      checkOutput("reset.divisor_out",  32'(divisorOut),  32'd3);
      checkOutput("reset.load_pending", 32'(loadPending), 32'd0);
      applyStimulus(2);
      reset  = 1'b0;
      enable = 1'b1;

      // Default divisor 3: os tick every 4, mid on the 8th, bit on the 16th
      clearCounts();
      applyStimulus(16);
      checkCounts("default", 4, 1, 1);
      checkOutput("default.bit_tick_16", 32'(bitTick), 32'd1);

      // Hold for 5 cycles at prescaler 2, then two more cycles to the tick
      applyStimulus(2);
      enable = 1'b0;
      clearCounts();
      applyStimulus(5);
      checkCounts("hold", 0, 0, 0);
      enable = 1'b1;
      applyStimulus(1);
      checkOutput("resume.first", 32'(osTick), 32'd0);
      applyStimulus(1);
      checkOutput("resume.second", 32'(osTick), 32'd1);
      applyStimulus(12);
      checkOutput("resume.bit_end", 32'(bitTick), 32'd1);

      // Load 7 mid-bit; takes effect at the boundary
      applyStimulus(6);
      divisorIn   = 16'd7;
      divisorLoad = 1'b1;
      applyStimulus(1);
      divisorLoad = 1'b0;
      checkOutput("load7.pending",     32'(loadPending), 32'd1);
      checkOutput("load7.still_old",   32'(divisorOut),  32'd3);
      applyStimulus(8);
      checkOutput("load7.wait",        32'(loadPending), 32'd1);
      applyStimulus(1);
      checkOutput("load7.bit_tick",    32'(bitTick),     32'd1);
      checkOutput("load7.divisor_out", 32'(divisorOut),  32'd7);
      checkOutput("load7.cleared",     32'(loadPending), 32'd0);
      clearCounts();
      applyStimulus(32);
      checkCounts("div7", 4, 1, 1);
      checkOutput("div7.bit_tick_32", 32'(bitTick), 32'd1);

      // Restart with simultaneous load of 0
      restart     = 1'b1;
      divisorLoad = 1'b1;
      divisorIn   = 16'd0;
      applyStimulus(1);
      restart     = 1'b0;
      divisorLoad = 1'b0;
      checkOutput("restart0.divisor_out",  32'(divisorOut),  32'd0);
      checkOutput("restart0.load_pending", 32'(loadPending), 32'd0);
      checkOutput("restart0.os_tick",      32'(osTick),      32'd0);
      clearCounts();
      applyStimulus(8);
      checkCounts("div0", 8, 2, 2);

      // Two loads before a boundary: last write wins
      restart     = 1'b1;
      divisorLoad = 1'b1;
      divisorIn   = 16'd3;
      applyStimulus(1);
      restart     = 1'b0;
      divisorLoad = 1'b0;
      sawFive     = 1'b0;
      applyStimulus(2);
      divisorIn   = 16'd5;
      divisorLoad = 1'b1;
      applyStimulus(1);
      divisorLoad = 1'b0;
      applyStimulus(1);
      divisorIn   = 16'd9;
      divisorLoad = 1'b1;
      applyStimulus(1);
      divisorLoad = 1'b0;
      checkOutput("reload.still_old", 32'(divisorOut),  32'd3);
      checkOutput("reload.pending",   32'(loadPending), 32'd1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         applyStimulus(1);
         if (bitTick) found = 1'b1;
      end
      checkOutput("reload.boundary_seen", 32'(found),      32'd1);
      checkOutput("reload.divisor_out",   32'(divisorOut), 32'd9);
      clearCounts();
      applyStimulus(40);
      checkCounts("div9", 4, 1, 1);
      checkOutput("reload.never_five", 32'(sawFive), 32'd0);

      // Asynchronous reset mid-bit while an os tick is high and a load waits
      divisorIn   = 16'd7;
      divisorLoad = 1'b1;
      applyStimulus(1);
      divisorLoad = 1'b0;
      applyStimulus(9);
      checkOutput("prereset.os_tick",      32'(osTick),      32'd1);
      checkOutput("prereset.load_pending", 32'(loadPending), 32'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("asyncreset.os_tick",      32'(osTick),      32'd0);
      checkOutput("asyncreset.divisor_out",  32'(divisorOut),  32'd3);
      checkOutput("asyncreset.load_pending", 32'(loadPending), 32'd0);
      applyStimulus(2);
      reset = 1'b0;
      clearCounts();
      applyStimulus(4);
      checkCounts("postreset", 1, 0, 0);
      checkOutput("postreset.os_tick_4", 32'(osTick), 32'd1);

      applyStimulus(2);
      checking = 1'b0;
      $display("[TB] %0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
